// File: rtl/cofre_controle.sv
// Combination safe controller: code storage, attempt capture,
// failed-attempt counting and timed lockout.
module cofre_controle #(
    parameter int LARG        = 4,
    parameter int MAX_ERROS   = 3,
    parameter int BLOQ_CICLOS = 50000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [LARG-1:0] chaves,
    input  logic            btn_gravar,
    input  logic            btn_fechar,
    input  logic            btn_tentar,
    input  logic            igual,
    output logic [LARG-1:0] senha,
    output logic [LARG-1:0] tentativa,
    output logic            aberto,
    output logic            bloqueado,
    output logic [1:0]      erros,
    output logic            tent_valida
);

    localparam int CW = (BLOQ_CICLOS > 1) ? $clog2(BLOQ_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_INI = CW'(BLOQ_CICLOS - 1);
    localparam logic [1:0] ERR_MAX = 2'(MAX_ERROS);
    localparam logic [2:0] ERR_LIM = 3'(MAX_ERROS);

    typedef enum logic [1:0] {
        ABERTO    = 2'd0,
        FECHADO   = 2'd1,
        AVALIA    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    estado_t         estado;
    estado_t         estado_n;
    logic [LARG-1:0] senha_n;
    logic [LARG-1:0] tent_n;
    logic [1:0]      erros_n;
    logic [2:0]      erros_inc;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;

    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] ev;
    logic       ev_gravar;
    logic       ev_fechar;
    logic       ev_tentar;

    // Bit order: {tentar, fechar, gravar}
    assign btn_raw   = {btn_tentar, btn_fechar, btn_gravar};
    assign ev        = sync2 & ~prev;
    assign ev_gravar = ev[0];
    assign ev_fechar = ev[1];
    assign ev_tentar = ev[2];

    assign aberto    = (estado == ABERTO);
    assign bloqueado = (estado == BLOQUEADO);
    assign erros_inc = {1'b0, erros} + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            estado    <= ABERTO;
            senha     <= '0;
            tentativa <= '0;
            erros     <= '0;
            cnt       <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            prev      <= sync2;
            estado    <= estado_n;
            senha     <= senha_n;
            tentativa <= tent_n;
            erros     <= erros_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        estado_n    = estado;
        senha_n     = senha;
        tent_n      = tentativa;
        erros_n     = erros;
        cnt_n       = cnt;
        tent_valida = 1'b0;
        case (estado)
            ABERTO: begin
                if (ev_gravar) begin
                    senha_n = chaves;
                end else if (ev_fechar) begin
                    estado_n = FECHADO;
                end
            end
            FECHADO: begin
                if (ev_tentar) begin
                    tent_n      = chaves;
                    tent_valida = 1'b1;
                    estado_n    = AVALIA;
                end
            end
            AVALIA: begin
                if (igual) begin
                    estado_n = ABERTO;
                    erros_n  = 2'd0;
                end else if (erros_inc < ERR_LIM) begin
                    erros_n  = erros_inc[1:0];
                    estado_n = FECHADO;
                end else begin
                    erros_n  = ERR_MAX;
                    estado_n = BLOQUEADO;
                    cnt_n    = CNT_INI;
                end
            end
            BLOQUEADO: begin
                if (cnt == '0) begin
                    estado_n = FECHADO;
                    erros_n  = 2'd0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: estado_n = ABERTO;
        endcase
    end

endmodule
